// File: rtl/checker_pixel_renderer.sv
// Pixel-colour stage for the checkers display. Three-register pipeline:
// S1 decodes the board square and issues the board RAM read, S2 computes
// the squared distance from the square centre, S3 resolves colour priority
// against the RAM data and registers the DAC outputs.
module checker_pixel_renderer #(
    parameter int H_VIS_START  = 144,
    parameter int V_VIS_START  = 35,
    parameter int BOARD_X      = 80,
    parameter int BOARD_Y      = 0,
    parameter int SQUARE       = 60,
    parameter int PIECE_R      = 24,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] cursor_row,
    input  logic [2:0] cursor_col,
    input  logic       sel_valid,
    input  logic [2:0] sel_row,
    input  logic [2:0] sel_col,
    output logic [5:0] board_rd_addr,
    input  logic [2:0] board_rd_data,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_blank_n,
    output logic       hsync_out,
    output logic       vsync_out
);
    localparam int OW = $clog2(SQUARE);
    localparam int CW = $clog2(BLINK_FRAMES);

    typedef struct packed {
        logic          vis;
        logic          inb;
        logic [2:0]    row;
        logic [2:0]    col;
        logic [OW-1:0] ox;
        logic [OW-1:0] oy;
    } s1_t;

    typedef struct packed {
        logic       vis;
        logic       inb;
        logic [2:0] row;
        logic [2:0] col;
        logic       border;
        logic [11:0] d2;
    } s2_t;

    s1_t s1, s1_c;
    s2_t s2, s2_c;
    logic [1:0] hs_d, vs_d;
    logic [11:0] x, y, base_x, base_y;
    logic signed [6:0] dx, dy;
    logic signed [13:0] dx2, dy2;
    logic [7:0] r_c, g_c, b_c;
    logic [2:0] cur_row_sh, cur_col_sh, sel_row_sh, sel_col_sh;
    logic sel_v_sh, blink_on;
    logic [CW-1:0] frame_cnt;
    logic frame_start;

    // Offsets relative to the board origin; negative values wrap high so a
    // single unsigned compare against the board size covers both edges.
    assign x = {2'b00, h_count} - 12'(H_VIS_START + BOARD_X);
    assign y = {2'b00, v_count} - 12'(V_VIS_START + BOARD_Y);
    assign frame_start = (h_count == 10'd0) && (v_count == 10'd0);

    // S1 decode: visibility, board membership, square index via compare chain
    always_comb begin
        s1_c     = '0;
        base_x   = '0;
        base_y   = '0;
        s1_c.vis = (h_count >= 10'(H_VIS_START)) && (h_count < 10'(H_VIS_START + 640)) &&
                   (v_count >= 10'(V_VIS_START)) && (v_count < 10'(V_VIS_START + 480));
        s1_c.inb = s1_c.vis && (x < 12'(8 * SQUARE)) && (y < 12'(8 * SQUARE));
        for (int i = 1; i < 8; i++) begin
            if (x >= 12'(i * SQUARE)) begin
                s1_c.col = 3'(i);
                base_x   = 12'(i * SQUARE);
            end
            if (y >= 12'(i * SQUARE)) begin
                s1_c.row = 3'(i);
                base_y   = 12'(i * SQUARE);
            end
        end
        s1_c.ox = OW'(x - base_x);
        s1_c.oy = OW'(y - base_y);
    end

    // S2 geometry: centre distance squared and square border flag
    always_comb begin
        dx        = 7'(s1.ox) - 7'(SQUARE / 2);
        dy        = 7'(s1.oy) - 7'(SQUARE / 2);
        dx2       = dx * dx;
        dy2       = dy * dy;
        s2_c      = '0;
        s2_c.vis  = s1.vis;
        s2_c.inb  = s1.inb;
        s2_c.row  = s1.row;
        s2_c.col  = s1.col;
        s2_c.d2   = 12'(dx2) + 12'(dy2);
        s2_c.border = (s1.ox < OW'(3)) || (s1.oy < OW'(3)) ||
                      (s1.ox >= OW'(SQUARE - 3)) || (s1.oy >= OW'(SQUARE - 3));
    end

    // S3 colour priority against board RAM data returned this cycle
    always_comb begin
        r_c = 8'd0;
        g_c = 8'd0;
        b_c = 8'd0;
        if (!s2.vis || !s2.inb) begin
            r_c = 8'd0;
        end else if (sel_v_sh && s2.border && s2.row == sel_row_sh && s2.col == sel_col_sh) begin
            g_c = 8'd255;
        end else if (blink_on && s2.border && s2.row == cur_row_sh && s2.col == cur_col_sh) begin
            b_c = 8'd255;
        end else if (board_rd_data[0] && board_rd_data[2] &&
                     s2.d2 < 12'((PIECE_R / 2) * (PIECE_R / 2))) begin
            r_c = 8'd255; g_c = 8'd215;
        end else if (board_rd_data[0] && s2.d2 < 12'(PIECE_R * PIECE_R)) begin
            if (board_rd_data[1]) begin
                r_c = 8'd40; g_c = 8'd40; b_c = 8'd40;
            end else begin
                r_c = 8'd255;
            end
        end else if (s2.row[0] ^ s2.col[0]) begin
            r_c = 8'd181; g_c = 8'd136; b_c = 8'd99;
        end else begin
            r_c = 8'd240; g_c = 8'd217; b_c = 8'd181;
        end
    end

    // Pipeline registers; syncs idle high so a flushed pipe emits inactive sync
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1            <= '0;
            s2            <= '0;
            board_rd_addr <= '0;
            hs_d          <= '1;
            vs_d          <= '1;
            hsync_out     <= 1'b1;
            vsync_out     <= 1'b1;
            vga_r         <= '0;
            vga_g         <= '0;
            vga_b         <= '0;
            vga_blank_n   <= 1'b0;
        end else begin
            s1 <= s1_c;
            if (s1_c.inb) board_rd_addr <= {s1_c.row, s1_c.col};
            s2          <= s2_c;
            hs_d        <= {hs_d[0], hsync_in};
            vs_d        <= {vs_d[0], vsync_in};
            hsync_out   <= hs_d[1];
            vsync_out   <= vs_d[1];
            vga_r       <= r_c;
            vga_g       <= g_c;
            vga_b       <= b_c;
            vga_blank_n <= s2.vis;
        end
    end

    // Frame-start shadows and blink timer so highlights never tear mid-frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_row_sh <= '0;
            cur_col_sh <= '0;
            sel_v_sh   <= 1'b0;
            sel_row_sh <= '0;
            sel_col_sh <= '0;
            frame_cnt  <= '0;
            blink_on   <= 1'b1;
        end else if (frame_start) begin
            cur_row_sh <= cursor_row;
            cur_col_sh <= cursor_col;
            sel_v_sh   <= sel_valid;
            sel_row_sh <= sel_row;
            sel_col_sh <= sel_col;
            if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_checker_pixel_renderer.sv
// Scoreboard bench: stimulus pushes expected outputs with a due cycle,
// an independent monitor pops and compares on each falling edge.
module tb_checker_pixel_renderer;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] h_count, v_count;
    logic       hsync_in, vsync_in;
    logic [2:0] cursor_row, cursor_col, sel_row, sel_col;
    logic       sel_valid;
    logic [5:0] board_rd_addr;
    logic [2:0] board_rd_data;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_blank_n, hsync_out, vsync_out;

    logic [2:0] mem [64];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int fs_total = 0;

    typedef struct {
        int         due;
        bit         is_addr;
        logic [7:0] r, g, b;
        logic       bl, hs, vs;
        logic [5:0] addr;
        string      nm;
    } exp_t;
    exp_t q[$];

    checker_pixel_renderer dut (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .sel_valid(sel_valid), .sel_row(sel_row), .sel_col(sel_col),
        .board_rd_addr(board_rd_addr), .board_rd_data(board_rd_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_blank_n(vga_blank_n),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Board RAM with one-cycle synchronous read
    always @(posedge clk) board_rd_data <= mem[board_rd_addr];

    task automatic push(input int due, input bit is_addr, input logic [7:0] r, g, b,
                        input logic bl, hs, vs, input logic [5:0] a, input string nm);
        exp_t e;
        e.due = due; e.is_addr = is_addr; e.r = r; e.g = g; e.b = b;
        e.bl = bl; e.hs = hs; e.vs = vs; e.addr = a; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic drive(input int hh, input int vv, input logic hs, input logic vs);
        @(negedge clk);
        h_count = 10'(hh); v_count = 10'(vv); hsync_in = hs; vsync_in = vs;
        if (rst && hh == 0 && vv == 0) fs_total++;
    endtask

    task automatic idle();
        drive(100, 200, 1'b1, 1'b1);
    endtask

    // One visible pixel, expected colour 3 clocks later, optional address check
    task automatic pix(input int hh, input int vv, input logic [7:0] r, g, b,
                       input int addr, input string nm);
        drive(hh, vv, 1'b1, 1'b1);
        push(cyc + 3, 1'b0, r, g, b, 1'b1, 1'b1, 1'b1, '0, nm);
        if (addr >= 0) push(cyc + 1, 1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0, 6'(addr), {nm, "_addr"});
        repeat (3) idle();
    endtask

    task automatic fstart();
        drive(0, 0, 1'b1, 1'b1);
        idle();
    endtask

    // Cursor square (0,0) top-left border pixel: blue while blink is on
    task automatic bpix(input string nm);
        if (((fs_total / 30) % 2) == 0) pix(224, 35, 8'd0, 8'd0, 8'd255, -1, nm);
        else                            pix(224, 35, 8'd240, 8'd217, 8'd181, -1, nm);
    endtask

    task automatic release_rst(input string nm);
        @(negedge clk);
        rst = 1'b1; h_count = '0; v_count = '0; hsync_in = 1'b1; vsync_in = 1'b1;
        fs_total = 1;
        for (int i = 1; i <= 3; i++)
            push(cyc + i, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1, '0, nm);
        drive(0, 0, 1'b1, 1'b1);
        drive(0, 0, 1'b1, 1'b1);
    endtask

    // Monitor: compares every expectation whose due cycle has arrived
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.is_addr) begin
                    if (board_rd_addr !== e.addr) begin
                        errors++;
                        $display("FAIL %s addr got %0d want %0d", e.nm, board_rd_addr, e.addr);
                    end
                end else if ({vga_r, vga_g, vga_b, vga_blank_n, hsync_out, vsync_out} !==
                             {e.r, e.g, e.b, e.bl, e.hs, e.vs}) begin
                    errors++;
                    $display("FAIL %s got rgb=%0d,%0d,%0d bl=%b hs=%b vs=%b want rgb=%0d,%0d,%0d bl=%b hs=%b vs=%b",
                             e.nm, vga_r, vga_g, vga_b, vga_blank_n, hsync_out, vsync_out,
                             e.r, e.g, e.b, e.bl, e.hs, e.vs);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        for (int i = 0; i < 64; i++) mem[i] = 3'b000;
        rst = 1'b0; h_count = '0; v_count = '0; hsync_in = 1'b1; vsync_in = 1'b1;
        cursor_row = 3'd7; cursor_col = 3'd7; sel_valid = 1'b0; sel_row = '0; sel_col = '0;
        repeat (3) @(negedge clk);
        push(cyc, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1, '0, "rst_hold");
        release_rst("rst_flush");
        idle(); idle();

        // Pieces and squares in row 0 / row 1
        mem[0] = 3'b001;
        pix(254, 65, 8'd255, 8'd0, 8'd0, 0, "red_centre");
        mem[0] = 3'b101;
        pix(254, 65, 8'd255, 8'd215, 8'd0, 0, "king_centre");
        pix(274, 65, 8'd255, 8'd0, 8'd0, -1, "king_ring_red");
        pix(283, 65, 8'd240, 8'd217, 8'd181, -1, "outside_piece");
        pix(314, 65, 8'd181, 8'd136, 8'd99, 1, "odd_empty");
        mem[10] = 3'b011;
        pix(374, 125, 8'd40, 8'd40, 8'd40, 10, "black_piece");
        pix(703, 65, 8'd181, 8'd136, 8'd99, 7, "last_col");
        pix(704, 65, 8'd0, 8'd0, 8'd0, -1, "right_of_board");
        pix(150, 100, 8'd0, 8'd0, 8'd0, -1, "left_of_board");

        // Blanking with sync pass-through
        drive(100, 200, 1'b0, 1'b1);
        push(cyc + 3, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, '0, "blank_hs_low");
        drive(799, 520, 1'b1, 1'b0);
        push(cyc + 3, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, '0, "blank_vs_low");
        drive(799, 520, 1'b0, 1'b0);
        push(cyc + 3, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, "blank_both_low");
        repeat (3) idle();

        // Cursor and selection highlight
        cursor_row = 3'd0; cursor_col = 3'd0;
        fstart();
        pix(224, 35, 8'd0, 8'd0, 8'd255, -1, "cursor_border");
        sel_valid = 1'b1; sel_row = 3'd0; sel_col = 3'd0;
        fstart();
        pix(224, 35, 8'd0, 8'd255, 8'd0, -1, "sel_border");
        sel_valid = 1'b0;

        // Mid-frame cursor change waits for the next frame start
        cursor_row = 3'd7; cursor_col = 3'd7;
        fstart();
        cursor_row = 3'd0; cursor_col = 3'd0;
        pix(224, 35, 8'd240, 8'd217, 8'd181, -1, "cursor_mid_frame");
        fstart();
        bpix("cursor_next_frame");

        // Blink timing across frames 29/30/59/60
        while (fs_total < 61) begin
            fstart();
            if (fs_total == 29 || fs_total == 30 || fs_total == 59 || fs_total == 60)
                bpix($sformatf("blink_f%0d", fs_total));
        end

        // Asynchronous reset with a coloured, sync-low pixel in flight
        mem[0] = 3'b001;
        drive(254, 65, 1'b0, 1'b0);
        drive(100, 200, 1'b0, 1'b0);
        drive(100, 200, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        push(cyc, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1, '0, "async_rst");
        @(negedge clk);
        release_rst("rst_flush2");
        repeat (3) idle();

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
